ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_sync.sv | 31 +++
 rtl/ps2_host_tx.sv | 151 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller state encoding, default timing and parity helper.
// Used by the host transmitter and intended for reuse by the keyboard receiver.
package ps2_pkg;

    localparam int PS2_DEFAULT_CLK_HZ = 14_000_000;
    localparam int PS2_INHIBIT_DIV    = 10_000;   // 100 us
    localparam int PS2_TIMEOUT_DIV    = 500;      // 2 ms
    localparam int PS2_FRAME_BITS     = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_state_t;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for one raw PS/2 line, plus a falling-edge strobe
// taken between consecutive synchronized samples.
module ps2_sync (
    input  logic CLK,
    input  logic nRESET,
    input  logic line_in,
    output logic level,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    // Idle PS/2 lines float high, so reset to 1 to avoid a spurious fall.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
            prev_reg <= 1'b1;
        end else begin
            meta_reg <= line_in;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign level = sync_reg;
    assign fall  = prev_reg & ~sync_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame
// clocked by the device, ACK check and a shared inhibit/watchdog counter.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ      = PS2_DEFAULT_CLK_HZ,
    parameter int INHIBIT_CYC = CLK_HZ / PS2_INHIBIT_DIV,
    parameter int TIMEOUT_CYC = CLK_HZ / PS2_TIMEOUT_DIV
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    ps2_state_t                  state_reg, state_next;
    logic [CNT_W-1:0]            cnt_reg, cnt_next;
    logic [3:0]                  bit_idx_reg, bit_idx_next;
    logic [PS2_FRAME_BITS-1:0]   frame_reg, frame_next;
    logic                        done_reg, done_next;
    logic                        error_reg, error_next;

    logic clk_level;
    logic clk_fall;
    logic dat_level;
    logic dat_fall_unused;

    ps2_sync u_sync_clk (
        .CLK     (CLK),
        .nRESET  (nRESET),
        .line_in (ps2_clk_in),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    ps2_sync u_sync_dat (
        .CLK     (CLK),
        .nRESET  (nRESET),
        .line_in (ps2_dat_in),
        .level   (dat_level),
        .fall    (dat_fall_unused)
    );

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            frame_reg   <= '0;
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            frame_reg   <= frame_next;
            done_reg    <= done_next;
            error_reg   <= error_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + 1'b1;
        bit_idx_next = bit_idx_reg;
        frame_next   = frame_reg;
        done_next    = 1'b0;
        error_next   = 1'b0;
        tx_ready     = 1'b0;
        ps2_clk_oe   = 1'b0;
        ps2_dat_oe   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                tx_ready = 1'b1;
                cnt_next = '0;
                if (tx_valid) begin
                    // Frame, LSB first: start, data[7:0], parity, stop.
                    frame_next   = {1'b1, odd_parity(tx_data), tx_data, 1'b0};
                    bit_idx_next = '0;
                    state_next   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (cnt_reg == INHIBIT_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_RTS;
                end
            end
            ST_RTS: begin
                ps2_dat_oe   = 1'b1;
                bit_idx_next = '0;
                state_next   = ST_SHIFT;
            end
            ST_SHIFT: begin
                ps2_dat_oe = ~frame_reg[bit_idx_reg];
                if (clk_fall) begin
                    cnt_next     = '0;
                    bit_idx_next = bit_idx_reg + 1'b1;
                    if (bit_idx_reg == 4'd9)
                        state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    cnt_next = '0;
                    if (dat_level) begin
                        error_next = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_fall)
                    cnt_next = '0;
                if (clk_level && dat_level) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Watchdog wins over any other outcome, so done and error stay exclusive.
        if ((state_reg inside {ST_RTS, ST_SHIFT, ST_ACK, ST_WAIT_IDLE}) &&
            (cnt_reg == TIMEOUT_LAST)) begin
            done_next  = 1'b0;
            error_next = 1'b1;
            state_next = ST_IDLE;
        end
    end

    assign tx_done  = done_reg;
    assign tx_error = error_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model and a bit scoreboard.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INHIBIT = 1400;
    localparam int TIMEOUT = 28000;
    localparam int SLOW_H  = 560;   // half period of 12.5 kHz at 14 MHz
    localparam int FAST_H  = 40;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk_line, ps2_dat_line;

    assign ps2_clk_line = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_line = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .CLK_HZ      (14_000_000),
        .INHIBIT_CYC (INHIBIT),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .ps2_clk_in (ps2_clk_line),
        .ps2_dat_in (ps2_dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int checks = 0;
    int failures = 0;
    int base_done = 0;
    int base_err = 0;

    logic exp_bits[$];
    int   exp_outcome[$];   // 1 = done, 2 = error

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (tx_done)             done_cnt <= done_cnt + 1;
        if (tx_error)            err_cnt  <= err_cnt + 1;
        if (tx_done && tx_error) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic got);
        logic e;
        if (exp_bits.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_bits.pop_front();
            check(tag, {31'd0, got}, {31'd0, e});
        end
    endtask

    task automatic send(input logic [7:0] b, input bit push_bits);
        int ones;
        ones = 0;
        @(negedge CLK);
        check("ready_before_send", {31'd0, tx_ready}, 32'd1);
        base_done = done_cnt;
        base_err  = err_cnt;
        tx_data  = b;
        tx_valid = 1'b1;
        if (push_bits) begin
            exp_bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) begin
                exp_bits.push_back(b[i]);
                ones += int'(b[i]);
            end
            exp_bits.push_back((ones % 2) == 0);
            exp_bits.push_back(1'b1);
        end
        @(negedge CLK);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
    endtask

    task automatic wait_rts(output int inh, output int rts_at);
        int n;
        n = 0;
        inh = 0;
        while (ps2_dat_oe !== 1'b1 && n < 5000) begin
            if (ps2_clk_oe) inh++;
            @(negedge CLK);
            n++;
        end
        rts_at = cyc;
        check("rts_dat_oe", {31'd0, ps2_dat_oe}, 32'd1);
        check("rts_clk_released", {31'd0, ps2_clk_oe}, 32'd0);
        check("inhibit_len", inh, INHIBIT);
    endtask

    task automatic device_frame(input int h, input bit do_ack, input int reset_at, input bit poke);
        int inh, rts_at;
        wait_rts(inh, rts_at);
        repeat (h) @(negedge CLK);
        pop_check("start_bit", ps2_dat_line);
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (h) @(negedge CLK);
            if (i == reset_at) begin
                check("pre_reset_dat_oe", {31'd0, ps2_dat_oe}, 32'd1);
                nRESET = 1'b0;
                #1;
                check("reset_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
                check("reset_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
                dev_clk_low = 1'b0;
                exp_bits.delete();
                @(negedge CLK);
                nRESET = 1'b1;
                @(negedge CLK);
                check("ready_after_reset", {31'd0, tx_ready}, 32'd1);
                return;
            end
            if (poke && i == 5) begin
                check("ready_low_in_shift", {31'd0, tx_ready}, 32'd0);
                tx_data  = 8'h3C;
                tx_valid = 1'b1;
                @(negedge CLK);
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
            dev_clk_low = 1'b0;
            pop_check($sformatf("frame_bit%0d", i), ps2_dat_line);
            repeat (h) @(negedge CLK);
        end
        dev_dat_low = do_ack;
        repeat (h / 2) @(negedge CLK);
        dev_clk_low = 1'b1;
        repeat (h) @(negedge CLK);
        dev_clk_low = 1'b0;
        repeat (h / 2) @(negedge CLK);
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_outcome(input string tag);
        int n, code;
        n = 0;
        code = (exp_outcome.size() != 0) ? exp_outcome.pop_front() : 0;
        while (done_cnt == base_done && err_cnt == base_err && n < TIMEOUT + 2000) begin
            @(negedge CLK);
            n++;
        end
        repeat (20) @(negedge CLK);
        check({tag, "_done"}, done_cnt - base_done, (code == 1) ? 32'd1 : 32'd0);
        check({tag, "_error"}, err_cnt - base_err, (code == 2) ? 32'd1 : 32'd0);
        check({tag, "_ready"}, {31'd0, tx_ready}, 32'd1);
        check({tag, "_clk_oe"}, {31'd0, ps2_clk_oe}, 32'd0);
        check({tag, "_dat_oe"}, {31'd0, ps2_dat_oe}, 32'd0);
        $display("frame %s outcome done=%0d error=%0d", tag, done_cnt - base_done, err_cnt - base_err);
    endtask

    initial begin
        int inh, rts_at, err_at, n, oe_high;

        repeat (3) @(negedge CLK);
        #1;
        check("reset_ready", {31'd0, tx_ready}, 32'd1);
        check("reset_clk_oe0", {31'd0, ps2_clk_oe}, 32'd0);
        check("reset_dat_oe0", {31'd0, ps2_dat_oe}, 32'd0);
        check("reset_done", {31'd0, tx_done}, 32'd0);
        check("reset_error", {31'd0, tx_error}, 32'd0);
        @(negedge CLK);
        nRESET = 1'b1;
        repeat (5) @(negedge CLK);
        check("idle_ready", {31'd0, tx_ready}, 32'd1);

        // 8'hED at 12.5 kHz with ACK
        send(8'hED, 1'b1);
        exp_outcome.push_back(1);
        device_frame(SLOW_H, 1'b1, 0, 1'b0);
        wait_outcome("ed");

        send(8'h00, 1'b1);
        exp_outcome.push_back(1);
        device_frame(FAST_H, 1'b1, 0, 1'b0);
        wait_outcome("x00");

        send(8'hFF, 1'b1);
        exp_outcome.push_back(1);
        device_frame(FAST_H, 1'b1, 0, 1'b0);
        wait_outcome("xff");

        send(8'h07, 1'b1);
        exp_outcome.push_back(1);
        device_frame(FAST_H, 1'b1, 0, 1'b0);
        wait_outcome("x07");

        // device does not ACK
        send(8'h96, 1'b1);
        exp_outcome.push_back(2);
        device_frame(FAST_H, 1'b0, 0, 1'b0);
        wait_outcome("noack");

        // device never clocks after RTS
        send(8'h5A, 1'b0);
        exp_outcome.push_back(2);
        wait_rts(inh, rts_at);
        n = 0;
        while (tx_error !== 1'b1 && n < TIMEOUT + 100) begin
            @(negedge CLK);
            n++;
        end
        err_at = cyc;
        check("timeout_cycles", err_at - rts_at, TIMEOUT);
        wait_outcome("timeout");

        // reset asserted at fall 5 (bit 4 of 8'hA5 is 0, so data is driven low)
        send(8'hA5, 1'b1);
        device_frame(FAST_H, 1'b1, 5, 1'b0);
        repeat (100) @(negedge CLK);
        check("reset_no_done", done_cnt - base_done, 32'd0);
        check("reset_no_error", err_cnt - base_err, 32'd0);
        $display("frame reset_mid aborted");

        // restart after reset, with a tx_valid pulse in SHIFT that must be ignored
        send(8'h81, 1'b1);
        exp_outcome.push_back(1);
        device_frame(FAST_H, 1'b1, 0, 1'b1);
        wait_outcome("restart");
        oe_high = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (ps2_clk_oe) oe_high++;
        end
        check("ignored_request", oe_high, 32'd0);

        check("done_error_exclusive", both_cnt, 32'd0);
        check("scoreboard_drained", exp_bits.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
